// File: rtl/fifo_protocol_checker.sv
// Shadow-model protocol checker for a synchronous FIFO: tracks occupancy and data,
// flags pointer, flag, read-data and write-data violations with sticky status.
module fifo_protocol_checker #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned PTR_W      = 5,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned CHK_THRESH = 150,
    parameter int unsigned CHK_HI_MAX = 230
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Wr_enable,
    input  logic              rd_enable,
    input  logic              full,
    input  logic              empty,
    input  logic [PTR_W-1:0]  write_ptr,
    input  logic [PTR_W-1:0]  read_ptr,
    input  logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] data_out,
    input  logic              chk_en,
    input  logic              clr_err,
    output logic [5:0]        err_flags,
    output logic              err_any,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [2:0]        first_err,
    output logic [PTR_W-1:0]  mdl_count,
    output logic [CNT_W-1:0]  wr_acc_cnt
);

    localparam int unsigned AW     = PTR_W - 1;
    localparam int unsigned DEPTH  = 1 << AW;
    localparam logic [2:0]  NO_ERR = 3'd7;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     m_wptr;
    logic [AW-1:0]     m_rptr;
    logic [DATA_W-1:0] exp_q;
    logic              exp_v;
    logic              past_valid;
    logic              prev_wa;
    logic              prev_ra;
    logic [PTR_W-1:0]  prev_wptr;
    logic [PTR_W-1:0]  prev_rptr;

    logic              wa_c;
    logic              ra_c;
    logic              din_bad_c;
    logic [PTR_W-1:0]  exp_wptr_c;
    logic [PTR_W-1:0]  exp_rptr_c;
    logic [PTR_W-1:0]  count_nxt_c;
    logic [5:0]        fail_c;
    logic [5:0]        new_err_c;
    logic [5:0]        flags_nxt_c;
    logic [CNT_W-1:0]  cnt_base_c;
    logic [CNT_W-1:0]  cnt_nxt_c;
    logic [2:0]        first_base_c;
    logic [2:0]        first_nxt_c;
    logic [2:0]        lowest_c;

    // Check evaluation and next-state of the error record
    always_comb begin
        wa_c         = Wr_enable & ~full;
        ra_c         = rd_enable & ~empty;
        din_bad_c    = wa_c && (data_in[7:0] > 8'(CHK_THRESH))
                            && (data_in[DATA_W-1 -: 8] > 8'(CHK_HI_MAX));
        exp_wptr_c   = prev_wa ? prev_wptr + PTR_W'(1) : prev_wptr;
        exp_rptr_c   = prev_ra ? prev_rptr + PTR_W'(1) : prev_rptr;
        count_nxt_c  = mdl_count + PTR_W'(wa_c) - PTR_W'(ra_c);

        fail_c       = '0;
        fail_c[0]    = past_valid && (write_ptr != exp_wptr_c);
        fail_c[1]    = past_valid && (read_ptr != exp_rptr_c);
        fail_c[2]    = past_valid && (full != (mdl_count == PTR_W'(DEPTH)));
        fail_c[3]    = past_valid && (empty != (mdl_count == '0));
        fail_c[4]    = past_valid && exp_v && (data_out != exp_q);
        fail_c[5]    = din_bad_c;
        new_err_c    = chk_en ? fail_c : 6'b0;

        // A same-cycle clear is applied first so a fresh error survives it
        flags_nxt_c  = (clr_err ? 6'b0 : err_flags) | new_err_c;
        cnt_base_c   = clr_err ? '0 : err_cnt;
        cnt_nxt_c    = cnt_base_c;
        if ((|new_err_c) && (cnt_base_c != '1)) begin
            cnt_nxt_c = cnt_base_c + CNT_W'(1);
        end

        lowest_c = NO_ERR;
        for (int i = 5; i >= 0; i--) begin
            if (new_err_c[i]) begin
                lowest_c = 3'(i);
            end
        end
        first_base_c = clr_err ? NO_ERR : first_err;
        first_nxt_c  = ((first_base_c == NO_ERR) && (|new_err_c)) ? lowest_c : first_base_c;
    end

    // Reference data store; stale contents are unreachable once pointers reset
    always_ff @(posedge clk) begin
        if (wa_c) begin
            mem[m_wptr] <= data_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_wptr     <= '0;
            m_rptr     <= '0;
            exp_q      <= '0;
            exp_v      <= 1'b0;
            past_valid <= 1'b0;
            prev_wa    <= 1'b0;
            prev_ra    <= 1'b0;
            prev_wptr  <= '0;
            prev_rptr  <= '0;
            mdl_count  <= '0;
            wr_acc_cnt <= '0;
            err_flags  <= '0;
            err_any    <= 1'b0;
            err_cnt    <= '0;
            first_err  <= NO_ERR;
        end else begin
            past_valid <= 1'b1;
            prev_wa    <= wa_c;
            prev_ra    <= ra_c;
            prev_wptr  <= write_ptr;
            prev_rptr  <= read_ptr;
            mdl_count  <= count_nxt_c;
            exp_v      <= ra_c;
            if (wa_c) begin
                m_wptr <= m_wptr + AW'(1);
                if (wr_acc_cnt != '1) begin
                    wr_acc_cnt <= wr_acc_cnt + CNT_W'(1);
                end
            end
            if (ra_c) begin
                exp_q  <= mem[m_rptr];
                m_rptr <= m_rptr + AW'(1);
            end
            err_flags <= flags_nxt_c;
            err_any   <= |flags_nxt_c;
            err_cnt   <= cnt_nxt_c;
            first_err <= first_nxt_c;
        end
    end

endmodule
